sfr_write_sched: RTL

SFR_WRITE_SCHED -- requirements
Module: sfr_write_sched

---
 rtl/sfr_write_sched.sv | 100 ++++++++++
 1 files changed

// File: rtl/sfr_write_sched.sv
// sfr_write_sched: single-port SFR write scheduler.
// Grants one of EX, WB top/bot or a deferred WB write each cycle.
module sfr_write_sched #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              top_first,
    input  logic              ex_req,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic              wb_req_top,
    input  logic              wb_req_bot,
    input  logic [ADDR_W-1:0] wb_addr_top,
    input  logic [ADDR_W-1:0] wb_addr_bot,
    output logic [4:0]        sel_signals,
    output logic              sfr_we,
    output logic [ADDR_W-1:0] sfr_addr,
    output logic              ex_stall,
    output logic              pipe_hold,
    output logic              overrun_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEF_TOP = 2'd1,
        DEF_BOT = 2'd2
    } state_t;

    state_t            state;
    state_t            cur;
    state_t            nxt;
    logic [ADDR_W-1:0] def_addr;
    logic [ADDR_W-1:0] cap_addr;
    logic              ovr_set;

    // Grant selection: deferred > WB > EX; reset views the FSM as IDLE
    always_comb begin
        cur         = reset ? IDLE : state;
        nxt         = IDLE;
        sel_signals = '0;
        sfr_addr    = '0;
        pipe_hold   = 1'b0;
        ovr_set     = 1'b0;
        cap_addr    = top_first ? wb_addr_bot : wb_addr_top;
        if (!flush) begin
            unique case (cur)
                DEF_TOP: begin
                    sel_signals[3] = 1'b1;
                    sfr_addr       = def_addr;
                    ovr_set        = wb_req_top | wb_req_bot;
                end
                DEF_BOT: begin
                    sel_signals[4] = 1'b1;
                    sfr_addr       = def_addr;
                    ovr_set        = wb_req_top | wb_req_bot;
                end
                default: begin
                    if (wb_req_top && wb_req_bot) begin
                        pipe_hold = 1'b1;
                        if (top_first) begin
                            sel_signals[1] = 1'b1;
                            sfr_addr       = wb_addr_top;
                            nxt            = DEF_BOT;
                        end else begin
                            sel_signals[2] = 1'b1;
                            sfr_addr       = wb_addr_bot;
                            nxt            = DEF_TOP;
                        end
                    end else if (wb_req_top) begin
                        sel_signals[1] = 1'b1;
                        sfr_addr       = wb_addr_top;
                    end else if (wb_req_bot) begin
                        sel_signals[2] = 1'b1;
                        sfr_addr       = wb_addr_bot;
                    end else if (ex_req) begin
                        sel_signals[0] = 1'b1;
                        sfr_addr       = ex_addr;
                    end
                end
            endcase
        end
        sfr_we   = |sel_signals;
        ex_stall = ex_req & ~flush & ~sel_signals[0];
    end

    // FSM state, deferred address capture and sticky overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            def_addr    <= '0;
            overrun_err <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != IDLE) def_addr <= cap_addr;
            if (ovr_set) overrun_err <= 1'b1;
        end
    end

endmodule
